// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one combinational bfloat16 fpu between two requesters.
// Ports:
//   clk, rst (sync, active-high)
//   reqN_valid_i/ready_o/mode_i/a_i/b_i for requesters 0 and 1
//   rsp_valid_o/ready_i/id_o/data_o/ovf_o/err_o for the result stream.
// Build option: FPU_ARB_RR_EN selects round-robin grant.
// Without it, grant is fixed priority with requester 0 winning.

module fpu (
   input  logic [3:0]  mode_i,
   input  logic [15:0] in1_i,
   input  logic [15:0] in2_i,
   output logic [15:0] out_o,
   output logic        overflow_o
);

   logic       s1, s2, sb;
   logic [7:0] e1, e2, m1, m2;
   logic       z1, z2;

   // Zero-exponent inputs are treated as zero.
   // Results are truncated, never rounded.
   assign s1 = in1_i[15];
   assign s2 = in2_i[15];
   assign e1 = in1_i[14:7];
   assign e2 = in2_i[14:7];
   assign m1 = {1'b1, in1_i[6:0]};
   assign m2 = {1'b1, in2_i[6:0]};
   assign z1 = (e1 == 8'd0);
   assign z2 = (e2 == 8'd0);
   // Subtract is add with the second sign flipped.
   assign sb = s2 ^ mode_i[1];

   logic        swap, bs, ls;
   logic [7:0]  be, d;
   logic [10:0] bm, lm, lm_sh;
   logic [11:0] sum;
   logic [3:0]  lz;
   logic        found;
   logic [6:0]  nm;
   int          ae;
   logic [15:0] add_r;
   logic        add_v;

   always_comb begin
      // Bigger magnitude operand leads.
      // Mantissas carry 3 guard bits.
      swap  = in2_i[14:0] > in1_i[14:0];
      bs    = swap ? sb : s1;
      ls    = swap ? s1 : sb;
      be    = swap ? e2 : e1;
      d     = swap ? e2 - e1 : e1 - e2;
      bm    = {swap ? m2 : m1, 3'b000};
      lm    = {swap ? m1 : m2, 3'b000};
      lm_sh = (d > 8'd10) ? 11'd0 : lm >> d;
      if (bs == ls)
         sum = {1'b0, bm} + {1'b0, lm_sh};
      else
         sum = {1'b0, bm} - {1'b0, lm_sh};
      lz    = 4'd0;
      found = 1'b0;
      for (int i = 10; i >= 0; i--) begin
         if (!found && sum[i]) begin
            lz    = 4'(10 - i);
            found = 1'b1;
         end
      end
      nm = 7'((sum[10:0] << lz) >> 3);
      if (sum[11])
         ae = int'(be) + 1;
      else
         ae = int'(be) - int'(lz);
      add_v = 1'b0;
      if (z1 && z2)
         add_r = {s1 & sb, 15'd0};
      else if (z2)
         add_r = in1_i;
      else if (z1)
         add_r = {sb, in2_i[14:0]};
      else if (sum == 12'd0)
         add_r = 16'd0;
      else if (ae >= 255) begin
         add_r = {bs, 8'hFF, 7'd0};
         add_v = 1'b1;
      end else if (ae <= 0)
         add_r = {bs, 15'd0};
      else
         add_r = {bs, 8'(ae), sum[11] ? sum[10:4] : nm};
   end

   logic [8:0]  ph;
   int          me;
   logic        ms;
   logic [15:0] mul_r;
   logic        mul_v;

   always_comb begin
      ph    = 9'((16'(m1) * 16'(m2)) >> 7);
      me    = int'(e1) + int'(e2) - 127 + (ph[8] ? 1 : 0);
      ms    = s1 ^ s2;
      mul_v = 1'b0;
      if (z1 || z2)
         mul_r = {ms, 15'd0};
      else if (me >= 255) begin
         mul_r = {ms, 8'hFF, 7'd0};
         mul_v = 1'b1;
      end else if (me <= 0)
         mul_r = {ms, 15'd0};
      else
         mul_r = {ms, 8'(me), ph[8] ? ph[7:1] : ph[6:0]};
   end

   logic [8:0]  q;
   int          de;
   logic [15:0] div_r;
   logic        div_v;

   always_comb begin
      // Mantissa ratio lies in (0.5, 2), so q fits in 9 bits.
      q     = 9'({m1, 8'd0} / 16'(m2));
      de    = int'(e1) - int'(e2) + 126 + (q[8] ? 1 : 0);
      div_v = 1'b0;
      if (z2) begin
         div_r = {ms, 8'hFF, 7'd0};
         div_v = 1'b1;
      end else if (z1)
         div_r = {ms, 15'd0};
      else if (de >= 255) begin
         div_r = {ms, 8'hFF, 7'd0};
         div_v = 1'b1;
      end else if (de <= 0)
         div_r = {ms, 15'd0};
      else
         div_r = {ms, 8'(de), q[8] ? q[7:1] : q[6:0]};
   end

   always_comb begin
      out_o      = 16'd0;
      overflow_o = 1'b0;
      unique case (mode_i)
         4'b0001, 4'b0010: begin
            out_o      = add_r;
            overflow_o = add_v;
         end
         4'b0100: begin
            out_o      = mul_r;
            overflow_o = mul_v;
         end
         4'b1000: begin
            out_o      = div_r;
            overflow_o = div_v;
         end
         default: ;
      endcase
   end

endmodule

module fpu_arbiter #(
   parameter logic [15:0] ERR_DATA = 16'h7FC0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [3:0]  req0_mode_i,
   input  logic [15:0] req0_a_i,
   input  logic [15:0] req0_b_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [3:0]  req1_mode_i,
   input  logic [15:0] req1_a_i,
   input  logic [15:0] req1_b_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [15:0] rsp_data_o,
   output logic        rsp_ovf_o,
   output logic        rsp_err_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  mode_q, mode_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic        id_q, id_d;
   logic        rsp_id_q, rsp_id_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_ovf_q, rsp_ovf_d;
   logic        rsp_err_q, rsp_err_d;

   logic        gnt_id, any_v, idle, hs, mode_ok;
   logic [15:0] fpu_out;
   logic        fpu_ovf;

   fpu u_fpu (
      .mode_i     (mode_q),
      .in1_i      (a_q),
      .in2_i      (b_q),
      .out_o      (fpu_out),
      .overflow_o (fpu_ovf)
   );

`ifdef FPU_ARB_RR_EN
   logic lg_q, lg_d;

   // On contention the requester not granted last time wins.
   assign gnt_id = (req0_valid_i && req1_valid_i) ? ~lg_q : req1_valid_i;
   assign lg_d   = hs ? gnt_id : lg_q;

   always_ff @(posedge clk) begin
      if (rst)
         lg_q <= 1'b1;
      else
         lg_q <= lg_d;
   end
`else
   assign gnt_id = ~req0_valid_i;
`endif

   assign any_v = req0_valid_i | req1_valid_i;
   assign idle  = (state_q == IDLE) & ~rst;
   assign hs    = idle & any_v;

   assign req0_ready_o = hs & ~gnt_id;
   assign req1_ready_o = hs & gnt_id;

   assign mode_ok = (mode_q != 4'd0) && ((mode_q & (mode_q - 4'd1)) == 4'd0);

   assign rsp_valid_o = (state_q == RESP) & ~rst;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_ovf_o   = rsp_ovf_q;
   assign rsp_err_o   = rsp_err_q;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      rsp_ovf_d  = rsp_ovf_q;
      rsp_err_d  = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               mode_d  = gnt_id ? req1_mode_i : req0_mode_i;
               a_d     = gnt_id ? req1_a_i : req0_a_i;
               b_d     = gnt_id ? req1_b_i : req0_b_i;
               id_d    = gnt_id;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_id_d = id_q;
            if (mode_ok) begin
               rsp_data_d = fpu_out;
               rsp_ovf_d  = fpu_ovf;
               rsp_err_d  = 1'b0;
            end else begin
               rsp_data_d = ERR_DATA;
               rsp_ovf_d  = 1'b0;
               rsp_err_d  = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= 4'd0;
         a_q        <= 16'd0;
         b_q        <= 16'd0;
         id_q       <= 1'b0;
         rsp_id_q   <= 1'b0;
         rsp_data_q <= 16'd0;
         rsp_ovf_q  <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         a_q        <= a_d;
         b_q        <= b_d;
         id_q       <= id_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_ovf_q  <= rsp_ovf_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed checks of the shared-fpu arbiter.
// Expected values are hand-computed bfloat16 results.

module tb_fpu_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [3:0]  req0_mode_i, req1_mode_i;
   logic [15:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
   logic [15:0] rsp_data_o;
   logic        rsp_ovf_o, rsp_err_o;

   int n_tests = 0;
   int n_fail  = 0;

   fpu_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid_i (req0_valid_i),
      .req0_ready_o (req0_ready_o),
      .req0_mode_i  (req0_mode_i),
      .req0_a_i     (req0_a_i),
      .req0_b_i     (req0_b_i),
      .req1_valid_i (req1_valid_i),
      .req1_ready_o (req1_ready_o),
      .req1_mode_i  (req1_mode_i),
      .req1_a_i     (req1_a_i),
      .req1_b_i     (req1_b_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_id_o     (rsp_id_o),
      .rsp_data_o   (rsp_data_o),
      .rsp_ovf_o    (rsp_ovf_o),
      .rsp_err_o    (rsp_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit id, input logic v, input logic [3:0] md,
                        input logic [15:0] a, input logic [15:0] b);
      if (id) begin
         req1_valid_i = v;
         req1_mode_i  = md;
         req1_a_i     = a;
         req1_b_i     = b;
      end else begin
         req0_valid_i = v;
         req0_mode_i  = md;
         req0_a_i     = a;
         req0_b_i     = b;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Starts just after a rising edge with the arbiter in IDLE.
   task automatic run_op(input string tag, input bit id,
                         input logic [3:0] md, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_d,
                         input logic exp_o, input logic exp_e);
      drive(id, 1'b1, md, a, b);
      @(negedge clk);
      check({tag, "_rdy"}, id ? req1_ready_o : req0_ready_o, 1);
      check({tag, "_rdy_oth"}, id ? req0_ready_o : req1_ready_o, 0);
      tick();
      drive(id, 1'b0, 4'hF, 16'hFFFF, 16'hFFFF);
      @(negedge clk);
      check({tag, "_exec_v"}, rsp_valid_o, 0);
      tick();
      @(negedge clk);
      check({tag, "_v"}, rsp_valid_o, 1);
      check({tag, "_data"}, rsp_data_o, exp_d);
      check({tag, "_id"}, rsp_id_o, id);
      check({tag, "_ovf"}, rsp_ovf_o, exp_o);
      check({tag, "_err"}, rsp_err_o, exp_e);
      tick();
   endtask

   initial begin
      int   nr;
      logic eid;

      rst         = 1'b1;
      rsp_ready_i = 1'b1;
      drive(0, 1'b1, 4'b0001, 16'h3F80, 16'h4000);
      drive(1, 1'b1, 4'b0001, 16'h3F80, 16'h4000);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_rdy0", req0_ready_o, 0);
      check("rst_rdy1", req1_ready_o, 0);
      check("rst_valid", rsp_valid_o, 0);
      check("rst_data", rsp_data_o, 16'h0000);
      check("rst_id", rsp_id_o, 0);
      check("rst_flags", {rsp_ovf_o, rsp_err_o}, 0);
      tick();
      rst = 1'b0;
      drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
      drive(1, 1'b0, 4'd0, 16'd0, 16'd0);

      run_op("add", 0, 4'b0001, 16'h3F80, 16'h4000, 16'h4040, 0, 0);
      run_op("sub", 1, 4'b0010, 16'h4040, 16'h3F80, 16'h4000, 0, 0);
      run_op("subneg", 0, 4'b0010, 16'h3F80, 16'h4000, 16'hBF80, 0, 0);
      run_op("mul", 0, 4'b0100, 16'h4000, 16'h4000, 16'h4080, 0, 0);
      run_op("mulovf", 1, 4'b0100, 16'h7F00, 16'h7F00, 16'h7F80, 1, 0);
      run_op("mulzero", 1, 4'b0100, 16'h0000, 16'h4000, 16'h0000, 0, 0);
      run_op("div", 0, 4'b1000, 16'h4080, 16'h4000, 16'h4000, 0, 0);
      run_op("divzero", 1, 4'b1000, 16'h3F80, 16'h0000, 16'h7F80, 1, 0);
      run_op("bad3", 0, 4'b0011, 16'h3F80, 16'h4000, 16'h7FC0, 0, 1);
      run_op("bad0", 1, 4'b0000, 16'h7F00, 16'h7F00, 16'h7FC0, 0, 1);

      // Both requesters held valid.
      do_reset();
      drive(0, 1'b1, 4'b0100, 16'h4000, 16'h4000);
      drive(1, 1'b1, 4'b0010, 16'h4040, 16'h3F80);
      nr = 0;
      for (int c = 0; c < 40 && nr < 4; c++) begin
         @(negedge clk);
         if (rsp_valid_o) begin
`ifdef FPU_ARB_RR_EN
            eid = nr[0];
`else
            eid = 1'b0;
`endif
            check("both_id", rsp_id_o, eid);
            check("both_data", rsp_data_o, eid ? 16'h4000 : 16'h4080);
            nr++;
         end
      end
      check("both_count", nr, 4);
      tick();
      drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
      drive(1, 1'b0, 4'd0, 16'd0, 16'd0);

      // Response back-pressure with req1 pending.
      do_reset();
      rsp_ready_i = 1'b0;
      drive(0, 1'b1, 4'b0001, 16'h3F80, 16'h4000);
      @(negedge clk);
      check("bp_rdy0", req0_ready_o, 1);
      tick();
      drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
      drive(1, 1'b1, 4'b0010, 16'h4040, 16'h3F80);
      @(negedge clk);
      check("bp_exec_rdy1", req1_ready_o, 0);
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_valid", rsp_valid_o, 1);
         check("bp_data", rsp_data_o, 16'h4040);
         check("bp_id", rsp_id_o, 0);
         check("bp_flags", {rsp_ovf_o, rsp_err_o}, 0);
         check("bp_rdys", {req0_ready_o, req1_ready_o}, 0);
         tick();
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      check("bp_hs_v", rsp_valid_o, 1);
      check("bp_hs_rdy1", req1_ready_o, 0);
      tick();
      @(negedge clk);
      check("bp_after_v", rsp_valid_o, 0);
      check("bp_after_rdy1", req1_ready_o, 1);
      tick();
      drive(1, 1'b0, 4'd0, 16'd0, 16'd0);
      tick();
      @(negedge clk);
      check("bp_r1_v", rsp_valid_o, 1);
      check("bp_r1_id", rsp_id_o, 1);
      check("bp_r1_data", rsp_data_o, 16'h4000);
      tick();

      // Reset while an operation is in EXEC.
      drive(0, 1'b1, 4'b0100, 16'h4000, 16'h4000);
      @(negedge clk);
      check("ab_rdy0", req0_ready_o, 1);
      tick();
      drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
      rst = 1'b1;
      @(negedge clk);
      check("ab_rst_v", rsp_valid_o, 0);
      check("ab_rst_rdys", {req0_ready_o, req1_ready_o}, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("ab_data", rsp_data_o, 16'h0000);
      check("ab_id", rsp_id_o, 0);
      check("ab_flags", {rsp_ovf_o, rsp_err_o}, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("ab_no_rsp", rsp_valid_o, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter ERR_DATA, default 16'h7FC0, the result returned for a request whose mode is not one-hot.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid_i  input  1  request pending on requester N (N = 0, 1).
REQ-005 SHALL have ports reqN_ready_o  output  1  request accepted this cycle (N = 0, 1).
REQ-006 SHALL have ports reqN_mode_i  input  4  one-hot op: 0001 add, 0010 sub, 0100 mul, 1000 div.
REQ-007 SHALL have ports reqN_a_i / reqN_b_i  input  16  bfloat16 operands.
REQ-008 SHALL have port rsp_valid_o  output  1  response available.
REQ-009 SHALL have port rsp_ready_i  input  1  consumer accepts response.
REQ-010 SHALL have port rsp_id_o  output  1  requester index owning the response.
REQ-011 SHALL have port rsp_data_o  output  16  bfloat16 result.
REQ-012 SHALL have port rsp_ovf_o  output  1  FPU overflow flag for the result.
REQ-013 SHALL have port rsp_err_o  output  1  mode was not one-hot.

Function
REQ-014 SHALL instantiate one combinational fpu (ports mode_i, in1_i, in2_i, out_o, overflow_o) and share it between the two requesters.
REQ-015 SHALL run an FSM with states IDLE, EXEC and RESP.
REQ-016 In IDLE: grant is combinational on the valids; reqN_ready_o = IDLE & grant==N; at most one ready is high per cycle.
REQ-017 A handshake (valid & ready) SHALL register mode, operands and id, then go to EXEC; with no valid, stay in IDLE.
REQ-018 In EXEC, the fpu SHALL see only the registered operands; at the end of EXEC, out_o and overflow_o are captured into the response registers; next state is RESP.
REQ-019 Illegal mode (zero or more than one bit set): rsp_data_o = ERR_DATA, rsp_ovf_o = 0, rsp_err_o = 1; the fpu result is discarded.
REQ-020 In RESP: rsp_valid_o = 1 and all rsp_* stay stable until rsp_ready_i = 1, then go to IDLE; both reqN_ready_o = 0 throughout EXEC and RESP.
REQ-021 Latency: handshake in cycle T gives rsp_valid_o high in cycle T+2; peak throughput is one operation per 3 cycles.
REQ-022 Requester inputs SHALL be ignored outside the handshake cycle; changing them during EXEC/RESP has no effect on the result.
REQ-023 rsp_ready_i high while rsp_valid_o = 0 SHALL have no effect.
REQ-024 A requester dropping valid before its handshake SHALL lose nothing; the grant is re-evaluated every IDLE cycle.

Reset
REQ-025 rst high at a rising edge SHALL force IDLE, clear the response registers to 0 and set last-grant to 1, in any state.
REQ-026 An in-flight operation SHALL be discarded with no response emitted.
REQ-027 During and after reset: rsp_valid_o = 0, rsp_id_o = 0, rsp_data_o = 16'h0000, rsp_ovf_o = 0, rsp_err_o = 0, reqN_ready_o = 0 while rst is high.

Configuration
REQ-028 Macro FPU_ARB_RR_EN defined: round-robin grant; when both valids are high, grant goes to the requester not in last-grant; last-grant updates on every handshake.
REQ-029 FPU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; the last-grant register is not built.
REQ-030 With either setting, the first grant after reset with both valids high SHALL go to requester 0.

Verification
REQ-031 Req0 add 3F80 + 4000, rsp_ready_i = 1 -> rsp_valid_o at T+2, data 4040, id 0, ovf 0, err 0.
REQ-032 Both requesters valid continuously (req0 mul 4000*4000, req1 sub 4040-3F80) -> RR_EN: responses alternate id 0,1,0,1 with data 4080 and 4000; without RR_EN: every response is id 0.
REQ-033 Req1 mul 7F00*7F00 -> rsp_ovf_o = 1, rsp_data_o equal to the standalone fpu output for the same inputs.
REQ-034 Req0 with mode 0011 -> rsp_data_o 7FC0, rsp_err_o 1, rsp_ovf_o 0.
REQ-035 rsp_ready_i held 0 for 5 cycles -> rsp_* stable, both readies 0, pending req1 not accepted until the cycle after the response handshake.
REQ-036 rst asserted during EXEC -> next cycle IDLE, all outputs 0, no response for the aborted request.
